// File: rtl/apb_pkg.sv
// Shared definitions for the 8-bit APB peripheral bus: requester FSM states,
// bus widths and the timer register map.
package apb_pkg;

  // Requester FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  // Wait-state counter width; TIMEOUT is limited to 2..255 so it never wraps.
  localparam int unsigned WAIT_W = 8;

  // Timer register map.
  localparam logic [7:0] TMR_LOAD = 8'h00;
  localparam logic [7:0] TMR_CTRL = 8'h04;
  localparam logic [7:0] TMR_STAT = 8'h08;
  localparam logic [7:0] TMR_CNT  = 8'h0C;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: turns single valid/ready commands into one SETUP/ACCESS
// transfer each, waits for PREADY (bounded by TIMEOUT) and returns the
// captured read data or a timeout error over a valid/ready response port.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // Command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB requester side
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  // Last ACCESS cycle index before the transfer is abandoned.
  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT - 1);

  apb_state_e        r_state,     w_state_d;
  logic              r_psel,      w_psel_d;
  logic              r_penable,   w_penable_d;
  logic              r_pwrite,    w_pwrite_d;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_d;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic              r_rsp_err,   w_rsp_err_d;
  logic [WAIT_W-1:0] r_wait_cnt,  w_wait_cnt_d;

  logic              w_cmd_ready;

  // Only one transfer in flight: accept only when idle with no response pending.
  assign w_cmd_ready = (r_state == IDLE) && !r_rsp_valid;

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    w_state_d     = r_state;
    w_psel_d      = r_psel;
    w_penable_d   = r_penable;
    w_pwrite_d    = r_pwrite;
    w_paddr_d     = r_paddr;
    w_pwdata_d    = r_pwdata;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_rdata_d = r_rsp_rdata;
    w_rsp_err_d   = r_rsp_err;
    w_wait_cnt_d  = r_wait_cnt;

    unique case (r_state)
      IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_pwrite_d  = cmd_write;
          w_paddr_d   = cmd_addr;
          w_pwdata_d  = cmd_wdata;
          w_psel_d    = 1'b1;
          w_penable_d = 1'b0;
          w_state_d   = SETUP;
        end
      end

      SETUP: begin
        w_penable_d  = 1'b1;
        w_wait_cnt_d = '0;
        w_state_d    = ACCESS;
      end

      ACCESS: begin
        // PREADY is only meaningful here; a registered slave may still hold
        // it high in the cycle after ACCESS ends.
        if (PREADY) begin
          w_rsp_rdata_d = r_pwrite ? '0 : PRDATA;
          w_rsp_err_d   = 1'b0;
          w_psel_d      = 1'b0;
          w_penable_d   = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_state_d     = RESP;
        end else if (r_wait_cnt == WaitLast) begin
          w_rsp_rdata_d = '0;
          w_rsp_err_d   = 1'b1;
          w_psel_d      = 1'b0;
          w_penable_d   = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_state_d     = RESP;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = IDLE;
        end
      end

      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset abandons any transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_psel      <= w_psel_d;
      r_penable   <= w_penable_d;
      r_pwrite    <= w_pwrite_d;
      r_paddr     <= w_paddr_d;
      r_pwdata    <= w_pwdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
      r_wait_cnt  <= w_wait_cnt_d;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

  // PENABLE is never asserted without PSEL.
  a_enable_implies_sel : assert property (@(posedge PCLK) disable iff (PRESET)
    r_penable |-> r_psel);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master with a behavioural APB slave
// (timer register map plus RAM, registered PREADY, programmable wait states).
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  logic       PCLK;
  logic       PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY;
  logic [7:0] PADDR, PWDATA, PRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  apb_cmd_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- behavioural slave ----------------
  int         slave_waits = 0;
  bit         slave_dead  = 1'b0;
  logic       s_pready;
  logic [7:0] s_prdata;
  int         s_wcnt;
  logic [7:0] s_ram [256];
  logic [7:0] t_load, t_cnt;
  logic       t_run, t_stat;

  assign PREADY = s_pready;
  assign PRDATA = s_prdata;

  initial begin
    for (int i = 0; i < 256; i++) s_ram[i] = 8'(i) ^ 8'hA5;
  end

  always @(posedge PCLK) begin
    if (PRESET) begin
      s_pready <= 1'b0;
      s_prdata <= 8'h00;
      s_wcnt   <= 0;
      t_load   <= 8'h00;
      t_cnt    <= 8'h00;
      t_run    <= 1'b0;
      t_stat   <= 1'b0;
    end else begin
      s_pready <= 1'b0;
      if (t_run) begin
        if (t_cnt <= 8'd1) begin
          t_cnt  <= 8'h00;
          t_run  <= 1'b0;
          t_stat <= 1'b1;
        end else begin
          t_cnt <= t_cnt - 8'd1;
        end
      end
      if (PSEL && PENABLE && !s_pready && !slave_dead) begin
        if (s_wcnt == slave_waits) begin
          s_pready <= 1'b1;
          s_wcnt   <= 0;
          if (PWRITE) begin
            case (PADDR)
              TMR_LOAD: t_load <= PWDATA;
              TMR_CTRL: if (PWDATA[0]) begin
                t_cnt  <= t_load;
                t_run  <= 1'b1;
                t_stat <= 1'b0;
              end
              TMR_STAT, TMR_CNT: ;
              default: s_ram[PADDR] <= PWDATA;
            endcase
          end else begin
            case (PADDR)
              TMR_LOAD: s_prdata <= t_load;
              TMR_CTRL: s_prdata <= {7'd0, t_run};
              TMR_STAT: s_prdata <= {7'd0, t_stat};
              TMR_CNT:  s_prdata <= t_cnt;
              default:  s_prdata <= s_ram[PADDR];
            endcase
          end
        end else begin
          s_wcnt <= s_wcnt + 1;
        end
      end
    end
  end

  // ---------------- reference model of RAM contents ----------------
  logic [7:0] model_mem [256];

  // ---------------- observations of one transfer ----------------
  logic [7:0] obs_rd;
  logic       obs_err, obs_fsel, obs_fen, obs_psel_rsp;
  int         obs_lat, obs_nacc;
  bit         obs_stable, obs_ok;

  // One complete transfer with rsp_ready held high.
  task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    int guard;
    obs_ok     = 1'b0;
    obs_stable = 1'b1;
    obs_nacc   = 0;
    obs_lat    = 0;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    cmd_valid  = 1'b1;
    rsp_ready  = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge PCLK); #1;
      guard++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    obs_fsel  = PSEL;
    obs_fen   = PENABLE;
    while (!rsp_valid && obs_lat < 200) begin
      if (PSEL && (PADDR !== addr || PWDATA !== wd || PWRITE !== wr)) obs_stable = 1'b0;
      if (PSEL && PENABLE) obs_nacc++;
      @(posedge PCLK); #1;
      obs_lat++;
    end
    obs_ok       = rsp_valid;
    obs_rd       = rsp_rdata;
    obs_err      = rsp_err;
    obs_psel_rsp = PSEL;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got sel=%b en=%b wr=%b addr=%h wd=%h rv=%b rd=%h err=%b exp all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err);
    end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    logic [7:0] addrs [2];
    logic [7:0] datas [2];
    addrs[0] = TMR_LOAD; datas[0] = 8'h05;
    addrs[1] = TMR_CTRL; datas[1] = 8'h01;
    slave_waits = 0;
    for (int i = 0; i < 2; i++) begin
      do_xfer(1'b1, addrs[i], datas[i]);
      n_tests++;
      if (!obs_ok || obs_err !== 1'b0 || obs_rd !== 8'h00) begin
        n_fail++;
        $display("FAIL write_rsp[%0d] got ok=%b err=%b rd=%h exp ok=1 err=0 rd=00",
                 i, obs_ok, obs_err, obs_rd);
      end
      n_tests++;
      if (obs_fsel !== 1'b1 || obs_fen !== 1'b0 || obs_nacc != 2) begin
        n_fail++;
        $display("FAIL write_phases[%0d] got setup=%b/%b access=%0d exp 1/0 access=2",
                 i, obs_fsel, obs_fen, obs_nacc);
      end
      n_tests++;
      if (obs_lat != 3 || !obs_stable) begin
        n_fail++;
        $display("FAIL write_latency[%0d] got lat=%0d stable=%b exp lat=3 stable=1",
                 i, obs_lat, obs_stable);
      end
    end
  endtask

  task automatic test_timer_run;
    int  polls;
    bit  reached;
    do_xfer(1'b0, TMR_CNT, 8'h00);
    n_tests++;
    if (!obs_ok || obs_rd > 8'h05 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_first_cnt got ok=%b rd=%h err=%b exp rd<=05 err=0", obs_ok, obs_rd, obs_err);
    end
    reached = (obs_ok && obs_rd == 8'h00);
    polls = 0;
    while (!reached && polls < 20) begin
      do_xfer(1'b0, TMR_CNT, 8'h00);
      reached = (obs_ok && obs_rd == 8'h00);
      polls++;
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL timer_poll got cnt=%h exp 00 within 20 polls", obs_rd);
    end
    do_xfer(1'b0, TMR_STAT, 8'h00);
    n_tests++;
    if (!obs_ok || obs_rd !== 8'h01) begin
      n_fail++;
      $display("FAIL timer_stat got ok=%b rd=%h exp 01", obs_ok, obs_rd);
    end
  endtask

  task automatic test_timeout;
    slave_dead = 1'b1;
    do_xfer(1'b0, TMR_CNT, 8'h00);
    slave_dead = 1'b0;
    n_tests++;
    if (!obs_ok || obs_err !== 1'b1 || obs_rd !== 8'h00 || obs_psel_rsp !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rsp got ok=%b err=%b rd=%h psel=%b exp ok=1 err=1 rd=00 psel=0",
               obs_ok, obs_err, obs_rd, obs_psel_rsp);
    end
    n_tests++;
    if (obs_nacc != int'(TIMEOUT) || obs_lat != int'(TIMEOUT) + 1) begin
      n_fail++;
      $display("FAIL timeout_cycles got access=%0d lat=%0d exp access=%0d lat=%0d",
               obs_nacc, obs_lat, TIMEOUT, TIMEOUT + 1);
    end
  endtask

  task automatic test_backpressure;
    int         guard;
    logic [7:0] rd0;
    bit         held;
    slave_waits = 0;
    cmd_write = 1'b0;
    cmd_addr  = TMR_STAT;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge PCLK); #1;
      guard++;
    end
    @(posedge PCLK); #1;
    cmd_addr = TMR_LOAD;  // queued command, held by the source
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge PCLK); #1;
      guard++;
    end
    rd0 = rsp_rdata;
    n_tests++;
    if (rsp_valid !== 1'b1 || rd0 !== 8'h01) begin
      n_fail++;
      $display("FAIL bp_first_rsp got rv=%b rd=%h exp rv=1 rd=01", rsp_valid, rd0);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || cmd_ready !== 1'b0 || PSEL !== 1'b0)
        held = 1'b0;
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL bp_hold got rv=%b rd=%h cmd_ready=%b psel=%b exp 1/%h/0/0",
               rsp_valid, rsp_rdata, cmd_ready, PSEL, rd0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake got rv=%b psel=%b cmd_ready=%b exp 0/0/1",
               rsp_valid, PSEL, cmd_ready);
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    n_tests++;
    if (PSEL !== 1'b1 || PADDR !== TMR_LOAD) begin
      n_fail++;
      $display("FAIL bp_queued_accept got psel=%b addr=%h exp 1/%h", PSEL, PADDR, TMR_LOAD);
    end
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge PCLK); #1;
      guard++;
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h05) begin
      n_fail++;
      $display("FAIL bp_queued_rsp got rv=%b rd=%h exp 1/05", rsp_valid, rsp_rdata);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_random;
    logic       wr;
    logic [7:0] a, d, exp_rd;
    int         w;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'hA5;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(1, 0));
      a  = 8'($urandom_range(255, 16));
      d  = 8'($urandom);
      w  = int'($urandom_range(4, 0));
      slave_waits = w;
      if (wr) begin
        model_mem[a] = d;
        exp_rd = 8'h00;
      end else begin
        exp_rd = model_mem[a];
      end
      do_xfer(wr, a, d);
      n_tests++;
      if (!obs_ok || obs_rd !== exp_rd || obs_err !== 1'b0 || obs_lat != 3 + w || !obs_stable) begin
        n_fail++;
        $display("FAIL random[%0d] wr=%b addr=%h got ok=%b rd=%h err=%b lat=%0d stable=%b exp rd=%h err=0 lat=%0d",
                 n, wr, a, obs_ok, obs_rd, obs_err, obs_lat, obs_stable, exp_rd, 3 + w);
      end
    end
    slave_waits = 0;
  endtask

  task automatic test_reset_midstream;
    int guard;
    slave_waits = 2;
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_wdata = 8'h3C;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge PCLK); #1;
      guard++;
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    n_tests++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got sel=%b en=%b wr=%b addr=%h wd=%h rv=%b exp all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release got cmd_ready=%b psel=%b exp 1/0", cmd_ready, PSEL);
    end
    slave_waits = 0;
  endtask

  task automatic test_reset_in_access;
    int guard;
    bit saw_rsp;
    slave_waits = 3;
    cmd_write = 1'b0;
    cmd_addr  = 8'h30;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge PCLK); #1;
      guard++;
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    n_tests++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      n_fail++;
      $display("FAIL access_entry got sel=%b en=%b exp 1/1", PSEL, PENABLE);
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    n_tests++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      n_fail++;
      $display("FAIL access_reset got sel=%b en=%b exp 0/0", PSEL, PENABLE);
    end
    saw_rsp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL) saw_rsp = 1'b1;
    end
    n_tests++;
    if (saw_rsp) begin
      n_fail++;
      $display("FAIL access_reset_no_rsp got activity=1 exp 0");
    end
    slave_waits = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_timer_run();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_reset_in_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp $finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
